fetch_cycle: RTL and testbench

//  Instruction fetch stage, directly upstream of the decode stage. Owns the fetch PC and issues
//  in-order requests to instruction memory over a valid/ready handshake. Buffers returned words

---
 rtl/fetch_cycle.sv | 111 +++++++++++
 tb/tb_fetch_cycle.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers {pc, inst} pairs and presents the FIFO head to the F->D register.
module fetch_cycle #(
  parameter int                            XLEN               = 64,
  parameter int                            INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0]               RESET_PC           = '0,
  parameter int                            FIFO_DEPTH         = 4,
  parameter logic [INSTRUCTION_LENGTH-1:0] NOP                = 'h13
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_resp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          f_to_d_enable_ff,
  output logic                          fetch_valid,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [XLEN-1:0]               PC_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]               r_fetch_pc;
  logic [XLEN-1:0]               r_last_pc;
  logic [XLEN-1:0]               r_buf_pc   [FIFO_DEPTH];
  logic [INSTRUCTION_LENGTH-1:0] r_buf_inst [FIFO_DEPTH];
  logic [XLEN-1:0]               r_tag_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]              r_rd_ptr, r_wr_ptr, r_tag_rd, r_tag_wr;
  logic [CNT_W-1:0]              r_count, r_outstanding, r_discard;

  logic                          w_head_valid;
  logic                          w_pop;
  logic                          w_accept;
  logic                          w_keep;
  logic [CNT_W:0]                w_used;
  logic                          w_credit;

  assign w_head_valid   = (r_count != '0);
  assign fetch_valid    = rst & w_head_valid;
  assign instruction    = fetch_valid ? r_buf_inst[r_rd_ptr] : NOP;
  assign PC_out         = !rst ? RESET_PC : (w_head_valid ? r_buf_pc[r_rd_ptr] : r_last_pc);

  assign w_pop          = fetch_valid & f_to_d_enable_ff & ~redirect_valid;
  // Outstanding requests and buffered words both hold a slot, so every response has room.
  assign w_used         = {1'b0, r_outstanding} + {1'b0, r_count} - (CNT_W+1)'(w_pop);
  assign w_credit       = (w_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_valid = rst & ~redirect_valid & w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;
  assign w_keep         = rst & imem_resp_valid & ~redirect_valid & (r_discard == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_last_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (redirect_valid)
        r_fetch_pc <= redirect_pc;
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + XLEN'(4);

      if (w_accept)
        r_tag_wr <= r_tag_wr + PTR_W'(1);
      if (imem_resp_valid)
        r_tag_rd <= r_tag_rd + PTR_W'(1);
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_resp_valid);

      // Every response still owed to the old stream is dropped, including one arriving now.
      if (redirect_valid)
        r_discard <= r_outstanding - CNT_W'(imem_resp_valid);
      else if (imem_resp_valid && (r_discard != '0))
        r_discard <= r_discard - CNT_W'(1);

      if (redirect_valid) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_keep)
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_keep) - CNT_W'(w_pop);
      end

      if (w_head_valid)
        r_last_pc <= r_buf_pc[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    if (w_keep) begin
      r_buf_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd];
      r_buf_inst[r_wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: in-order variable-latency memory plus a stream-level model of the PCs
// decode must see (consecutive from reset/redirect target, each once, in order).
module tb_fetch_cycle;
  localparam int          XLEN   = 64;
  localparam int          IL     = 32;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOPW   = 32'h00000013;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [IL-1:0]   imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            f_to_d_enable_ff;
  logic            fetch_valid;
  logic [IL-1:0]   instruction;
  logic [XLEN-1:0] PC_out;

  fetch_cycle #(
    .XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .RESET_PC(RST_PC), .FIFO_DEPTH(4), .NOP(NOPW)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .f_to_d_enable_ff(f_to_d_enable_ff),
    .fetch_valid(fetch_valid), .instruction(instruction), .PC_out(PC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memq[$];
  int          total, bad, cyc, lat, last_due, epoch, out_all, nbuf;
  logic [63:0] exp_req, exp_pop, last_pc;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event (cycle %0d)", tag, cyc);
  endtask

  // One clock: drive memory, check outputs against the model, advance the model.
  task automatic step();
    bit   pop_e, rv_e;
    int   due;
    req_t r;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEADBEEF;
    if (rst && memq.size() > 0) begin
      if (memq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_of(memq[0].addr);
      end
    end
    #1;
    if (!rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_instruction", instruction, NOPW);
      chk("rst_pc_out", PC_out, RST_PC);
      memq.delete();
      out_all  = 0;
      nbuf     = 0;
      epoch++;
      exp_req  = RST_PC;
      exp_pop  = RST_PC;
      last_pc  = RST_PC;
      last_due = 0;
    end else begin
      pop_e = (nbuf != 0) && f_to_d_enable_ff && !redirect_valid;
      rv_e  = !redirect_valid && (out_all + nbuf - int'(pop_e) < 4);
      chk("fetch_valid", fetch_valid, nbuf != 0);
      if (nbuf != 0) begin
        chk("head_pc", PC_out, exp_pop);
        chk("head_inst", instruction, word_of(exp_pop));
        last_pc = exp_pop;
      end else begin
        chk("idle_pc", PC_out, last_pc);
        chk("idle_inst", instruction, NOPW);
      end
      chk("req_valid", imem_req_valid, rv_e);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      if (imem_resp_valid) begin
        r = memq.pop_front();
        out_all--;
        if (r.epoch == epoch && !redirect_valid) nbuf++;
      end
      if (pop_e) begin
        nbuf--;
        exp_pop += 64'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        memq.push_back('{addr: imem_req_addr, epoch: epoch, due: due});
        last_due = due;
        out_all++;
        exp_req += 64'd4;
      end
      if (redirect_valid) begin
        epoch++;
        nbuf    = 0;
        exp_req = redirect_pc;
        exp_pop = redirect_pc;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] target);
    int k;
    for (k = 0; k < 40; k++) begin
      if (fetch_valid) break;
      step();
    end
    if (k == 40) timeout(tag);
    else chk(tag, PC_out, target);
  endtask

  initial begin
    int k;
    total = 0; bad = 0; cyc = 0; lat = 1; last_due = 0; epoch = 0; out_all = 0; nbuf = 0;
    exp_req = RST_PC; exp_pop = RST_PC; last_pc = RST_PC;
    rst = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    f_to_d_enable_ff = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(negedge clk);

    // Reset held for three cycles, then the first request goes to RESET_PC.
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("first_req_addr", imem_req_addr, RST_PC);
    chk("first_req_valid", imem_req_valid, 1);

    // Streaming with a one-cycle memory.
    imem_req_ready = 1'b1; f_to_d_enable_ff = 1'b1; lat = 1;
    step(); step();
    chk("latency_valid_c2", fetch_valid, 1);
    chk("latency_pc_c2", PC_out, RST_PC);
    repeat (10) step();

    // Decode stall: head frozen, credits run out.
    f_to_d_enable_ff = 1'b0;
    repeat (6) step();
    #1;
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_head_valid", fetch_valid, 1);
    f_to_d_enable_ff = 1'b1;
    repeat (10) step();

    // Redirect with older requests outstanding on a slow memory.
    lat = 3;
    for (k = 0; k < 30; k++) begin
      if (out_all >= 2) break;
      step();
    end
    if (k == 30) timeout("slow_outstanding");
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_valid = 1'b0;
    chk("post_redirect_valid", fetch_valid, 0);
    wait_valid("redirect_first_pc", 64'h100);
    repeat (8) step();

    // Redirect landing in the same cycle as a response, decode enabled.
    lat = 1;
    repeat (6) step();
    for (k = 0; k < 30; k++) begin
      if (memq.size() > 0 && memq[0].due <= cyc) break;
      step();
    end
    if (k == 30) timeout("coincident_resp");
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    step();
    redirect_valid = 1'b0;
    chk("coincident_next_valid", fetch_valid, 0);
    wait_valid("coincident_first_pc", 64'h200);

    // Random ready/enable/redirect/latency traffic.
    for (int i = 0; i < 200; i++) begin
      imem_req_ready   = $urandom_range(0, 1) == 1;
      f_to_d_enable_ff = $urandom_range(0, 3) != 0;
      redirect_valid   = $urandom_range(0, 19) == 0;
      redirect_pc      = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
      step();
    end
    redirect_valid = 1'b0;

    // Reset in the middle of traffic with three requests outstanding.
    lat = 3; imem_req_ready = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (out_all == 3) break;
      f_to_d_enable_ff = $urandom_range(0, 1) == 1;
      step();
    end
    if (k == 200) timeout("mid_reset_outstanding");
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("restart_req_addr", imem_req_addr, RST_PC);
    for (int i = 0; i < 200; i++) begin
      imem_req_ready   = $urandom_range(0, 1) == 1;
      f_to_d_enable_ff = $urandom_range(0, 3) != 0;
      redirect_valid   = $urandom_range(0, 29) == 0;
      redirect_pc      = {$urandom, $urandom} & ~64'h3;
      lat              = $urandom_range(1, 3);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
